// File: rtl/mtr_pwm_ramp_drv_if.sv
// Speed-command / gate-drive bundle between the motor speed controller and the PWM driver.
interface mtr_pwm_ramp_drv_if #(
    parameter int NCH   = 2,
    parameter int SPD_W = 11
);
    logic                 en;
    logic [NCH*SPD_W-1:0] spd;
    logic [NCH-1:0]       pwm1;
    logic [NCH-1:0]       pwm2;
    logic                 period_tick;
    logic [NCH-1:0]       at_target;

    modport master (output en, spd, input pwm1, pwm2, period_tick, at_target);
    modport slave  (input en, spd, output pwm1, pwm2, period_tick, at_target);
endinterface

// File: rtl/mtr_pwm_ramp_drv.sv
// N-channel H-bridge PWM driver: signed speed -> slew-limited offset-binary duty,
// complementary gate pairs with dead time, all channels sharing one period counter.
module mtr_pwm_ramp_drv #(
    parameter int NCH       = 2,
    parameter int SPD_W     = 11,
    parameter int DEAD      = 8,
    parameter int RAMP_STEP = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    mtr_pwm_ramp_drv_if.slave   bus
);

    localparam int                     DT_W    = $clog2(DEAD + 1);
    localparam logic [SPD_W-1:0]       MID     = {1'b1, {(SPD_W-1){1'b0}}};
    localparam logic [SPD_W-1:0]       CNT_MAX = '1;
    localparam logic signed [SPD_W:0]  STEP_S  = (SPD_W+1)'(RAMP_STEP);
    localparam logic [SPD_W-1:0]       STEP_U  = SPD_W'(RAMP_STEP);
    localparam logic [DT_W-1:0]        DEAD_V  = DT_W'(DEAD);

    logic [SPD_W-1:0] cnt_q;
    logic [SPD_W-1:0] cnt_d;
    logic             periodTick;
    logic [NCH-1:0]   pwm1W;
    logic [NCH-1:0]   pwm2W;
    logic [NCH-1:0]   atW;

    assign cnt_d      = cnt_q + 1'b1;
    assign periodTick = (cnt_q == CNT_MAX);

    // The period counter free-runs even while coasting so all channels stay phase-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [SPD_W-1:0]        spdK;
        logic [SPD_W-1:0]        tgt;
        logic signed [SPD_W:0]   diff;
        logic [SPD_W-1:0]        cur_q;
        logic [SPD_W-1:0]        cur_d;
        logic                    raw_q;
        logic                    raw_d;
        logic [DT_W-1:0]         dt_q;
        logic [DT_W-1:0]         dt_d;
        logic                    at_q;
        logic                    at_d;

        assign spdK = bus.spd[k*SPD_W +: SPD_W];
        assign tgt  = spdK ^ MID;

        // Duty moves only at the period boundary so a PWM period never sees two duty values.
        always_comb begin
            diff  = $signed({1'b0, tgt}) - $signed({1'b0, cur_q});
            cur_d = cur_q;
            if (!bus.en) begin
                cur_d = MID;
            end else if (periodTick) begin
                if ((RAMP_STEP == 0) || ((diff <= STEP_S) && (diff >= -STEP_S))) begin
                    cur_d = tgt;
                end else if (diff > 0) begin
                    cur_d = cur_q + STEP_U;
                end else begin
                    cur_d = cur_q - STEP_U;
                end
            end
        end

        always_comb begin
            raw_d = bus.en & (cnt_q < cur_q);
            at_d  = (cur_q == tgt);
            dt_d  = dt_q;
            if (!bus.en || (raw_d != raw_q)) begin
                dt_d = '0;
            end else if (dt_q != DEAD_V) begin
                dt_d = dt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cur_q <= MID;
                raw_q <= 1'b0;
                dt_q  <= '0;
                at_q  <= 1'b0;
            end else begin
                cur_q <= cur_d;
                raw_q <= raw_d;
                dt_q  <= dt_d;
                at_q  <= at_d;
            end
        end

        // Gates open only once the raw level has held for the full dead time.
        assign pwm1W[k] =  raw_q & (dt_q == DEAD_V);
        assign pwm2W[k] = ~raw_q & (dt_q == DEAD_V);
        assign atW[k]   = at_q;
    end

    assign bus.pwm1        = pwm1W;
    assign bus.pwm2        = pwm2W;
    assign bus.at_target   = atW;
    assign bus.period_tick = periodTick;

endmodule

// File: tb/tb_mtr_pwm_ramp_drv.sv
// Randomised bench for mtr_pwm_ramp_drv: a ramped (step 64) and an unlimited (step 0)
// instance share stimulus and are compared every cycle against a behavioural model.
module tb_mtr_pwm_ramp_drv;

    localparam int NCH   = 2;
    localparam int SPD_W = 11;
    localparam int DEAD  = 8;
    localparam int PER   = 2048;
    localparam int MID   = 1024;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic [NCH*SPD_W-1:0] spd;

    int checks = 0;
    int errors = 0;
    bit cmpOn  = 0;

    mtr_pwm_ramp_drv_if #(.NCH(NCH), .SPD_W(SPD_W)) bus0 ();
    mtr_pwm_ramp_drv_if #(.NCH(NCH), .SPD_W(SPD_W)) bus1 ();

    assign bus0.en  = en;
    assign bus0.spd = spd;
    assign bus1.en  = en;
    assign bus1.spd = spd;

    mtr_pwm_ramp_drv #(.NCH(NCH), .SPD_W(SPD_W), .DEAD(DEAD), .RAMP_STEP(64)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    mtr_pwm_ramp_drv #(.NCH(NCH), .SPD_W(SPD_W), .DEAD(DEAD), .RAMP_STEP(0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    logic [NCH-1:0] pwm1A [2];
    logic [NCH-1:0] pwm2A [2];
    logic [NCH-1:0] atA   [2];
    logic           tickA [2];

    assign pwm1A[0] = bus0.pwm1;
    assign pwm1A[1] = bus1.pwm1;
    assign pwm2A[0] = bus0.pwm2;
    assign pwm2A[1] = bus1.pwm2;
    assign atA[0]   = bus0.at_target;
    assign atA[1]   = bus1.at_target;
    assign tickA[0] = bus0.period_tick;
    assign tickA[1] = bus1.period_tick;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: period position, duty and at_target per instance/channel, and a
    // short history of raw levels (2 = coasting/reset) used to decide gate outputs.
    int mCnt;
    int mCur  [2][NCH];
    bit mAt   [2][NCH];
    int hist  [2][NCH][$];

    function automatic int stepOf(input int i);
        return (i == 0) ? 64 : 0;
    endfunction

    function automatic int spdVal(input int k);
        logic signed [SPD_W-1:0] s;
        s = spd[k*SPD_W +: SPD_W];
        return int'(s);
    endfunction

    function automatic int rampTo(input int cur, input int tgt, input int step);
        int d;
        d = tgt - cur;
        if (step == 0 || (d <= step && d >= -step)) return tgt;
        return (d > 0) ? cur + step : cur - step;
    endfunction

    // A gate is on when the raw level is v and it has not changed (nor been coasting)
    // during the last DEAD cycles.
    function automatic bit expPwm(input int i, input int k, input int v);
        int n;
        int a;
        int b;
        n = hist[i][k].size();
        for (int j = n - DEAD; j < n; j++) begin
            a = hist[i][k][j];
            b = hist[i][k][j-1];
            if (a != v) return 1'b0;
            if (((b == 2) ? 0 : b) != a) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int tg;
        int old;
        if (!rst_n) begin
            mCnt = 0;
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < NCH; k++) begin
                    mCur[i][k] = MID;
                    mAt[i][k]  = 1'b0;
                    hist[i][k].delete();
                    repeat (DEAD + 1) hist[i][k].push_back(2);
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < NCH; k++) begin
                    tg  = spdVal(k) + MID;
                    old = mCur[i][k];
                    mAt[i][k] = (old == tg);
                    hist[i][k].push_back(en ? ((mCnt < old) ? 1 : 0) : 2);
                    void'(hist[i][k].pop_front());
                    if (!en) mCur[i][k] = MID;
                    else if (mCnt == PER - 1) mCur[i][k] = rampTo(old, tg, stepOf(i));
                end
            end
            mCnt = (mCnt + 1) % PER;
        end
    end

    task automatic checkOutput(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("[TB] FAIL %s[%0d] actual=%0d expected=%0d at %0t", name, idx, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cmpOn) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput("period_tick", i, int'(tickA[i]), int'(mCnt == PER - 1));
                for (int k = 0; k < NCH; k++) begin
                    checkOutput("at_target", i*NCH + k, int'(atA[i][k]), int'(mAt[i][k]));
                    checkOutput("pwm1", i*NCH + k, int'(pwm1A[i][k]), int'(expPwm(i, k, 1)));
                    checkOutput("pwm2", i*NCH + k, int'(pwm2A[i][k]), int'(expPwm(i, k, 0)));
                    checkOutput("overlap", i*NCH + k, int'(pwm1A[i][k] & pwm2A[i][k]), 0);
                end
            end
        end
    end

    task automatic applyStimulus(input bit enV, input int s0, input int s1);
        logic [SPD_W-1:0] a;
        logic [SPD_W-1:0] b;
        a   = SPD_W'(s0);
        b   = SPD_W'(s1);
        en  = enV;
        spd = {b, a};
    endtask

    task automatic waitTick();
        for (int n = 0; n < PER + 64; n++) begin
            @(negedge clk);
            if (tickA[0]) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL tick_timeout actual=none required=period_tick within %0d cycles", PER + 64);
    endtask

    task automatic measure(input int i, input int k, output int p1, output int p2);
        p1 = 0;
        p2 = 0;
        repeat (PER) begin
            @(negedge clk);
            p1 += int'(pwm1A[i][k]);
            p2 += int'(pwm2A[i][k]);
        end
    endtask

    task automatic checkAllZero(input string name);
        for (int i = 0; i < 2; i++) begin
            checkOutput({name, "_pwm1"}, i, int'(pwm1A[i]), 0);
            checkOutput({name, "_pwm2"}, i, int'(pwm2A[i]), 0);
            checkOutput({name, "_at"}, i, int'(atA[i]), 0);
            checkOutput({name, "_tick"}, i, int'(tickA[i]), 0);
        end
    endtask

    initial begin
        int p1;
        int p2;
        int s0;
        int s1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 0, 0);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        cmpOn = 1'b1;

        // Zero speed: duty 1024 on every channel.
        applyStimulus(1'b1, 0, 0);
        waitTick();
        waitTick();
        measure(0, 0, p1, p2);
        checkOutput("zero_pwm1_clks", 0, p1, 1016);
        checkOutput("zero_pwm2_clks", 0, p2, 1016);
        measure(1, 1, p1, p2);
        checkOutput("zero_pwm1_clks", 3, p1, 1016);
        checkOutput("zero_pwm2_clks", 3, p2, 1016);
        checkOutput("zero_at_target", 0, int'(atA[0]), 3);

        // +512 on channel 0: eight ramp steps of 64.
        repeat (10) @(negedge clk);
        applyStimulus(1'b1, 512, 0);
        repeat (8) waitTick();
        checkOutput("ramp_at_before8", 0, int'(atA[0][0]), 0);
        repeat (2) @(negedge clk);
        checkOutput("ramp_at_after8", 0, int'(atA[0][0]), 1);
        waitTick();
        measure(0, 0, p1, p2);
        checkOutput("ramp_pwm1_clks", 0, p1, 1528);
        checkOutput("ramp_pwm2_clks", 0, p2, 504);
        checkOutput("ramp_ch1_at", 1, int'(atA[0][1]), 1);

        // Full forward: ramps 1536 -> 2047 without wrapping.
        applyStimulus(1'b1, 1023, 1023);
        repeat (8) waitTick();
        repeat (2) @(negedge clk);
        checkOutput("full_at_target", 0, int'(atA[0][0]), 1);
        waitTick();
        measure(0, 0, p1, p2);
        checkOutput("full_pwm1_clks", 0, p1, 2039);
        checkOutput("full_pwm2_clks", 0, p2, 0);

        // Full reverse on the unlimited instance: duty 0 right after the next tick.
        applyStimulus(1'b1, -1024, -1024);
        waitTick();
        waitTick();
        measure(1, 0, p1, p2);
        checkOutput("rev_pwm1_clks", 2, p1, 0);
        checkOutput("rev_pwm2_clks", 2, p2, 2048);

        for (int seg = 0; seg < 8; seg++) begin
            s0 = int'($urandom_range(0, 2047)) - 1024;
            s1 = int'($urandom_range(0, 2047)) - 1024;
            if (seg == 2) s0 = 1023;
            if (seg == 3) s1 = -1024;
            applyStimulus($urandom_range(0, 4) != 0, s0, s1);
            repeat ($urandom_range(300, 1200)) @(negedge clk);
        end

        // Coast mid-period at cnt=300, then resume from zero speed.
        applyStimulus(1'b1, 512, -300);
        waitTick();
        repeat (301) @(negedge clk);
        applyStimulus(1'b0, 512, -300);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("coast_pwm1", i, int'(pwm1A[i]), 0);
            checkOutput("coast_pwm2", i, int'(pwm2A[i]), 0);
        end
        repeat (50) @(negedge clk);
        applyStimulus(1'b1, 512, -300);
        waitTick();
        repeat (2) @(negedge clk);
        checkOutput("resume_ramped_at", 0, int'(atA[0][0]), 0);
        checkOutput("resume_jump_at", 2, int'(atA[1][0]), 1);
        waitTick();
        repeat (500) @(negedge clk);

        // Asynchronous reset between clock edges.
        #3 rst_n = 1'b0;
        #1 checkAllZero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
